// File: rtl/rd2ex_operand_stage_if.sv
// READ->EXECUTE operand-stage bus: decoded instruction in, forwarding/hazard decisions in,
// rd2ex addresses and EXECUTE operands out. "slave" is the stage, "master" drives it.
interface rd2ex_operand_stage_if #(
    parameter int D_SIZE = 32,
    parameter int CNT_W  = 16
);
    logic              instr_valid_in;
    logic [6:0]        opcode_in;
    logic [2:0]        addr_op1_in;
    logic [2:0]        addr_op2_in;
    logic [2:0]        dest_in;
    logic              reg_re_in;
    logic [D_SIZE-1:0] rf_data1;
    logic [D_SIZE-1:0] rf_data2;
    logic [D_SIZE-1:0] result_wb;
    logic              df1;
    logic              df2;
    logic              freeze;
    logic              clear;

    logic [2:0]        addr_op1_rd2ex;
    logic [2:0]        addr_op2_rd2ex;
    logic [2:0]        dest_rd2ex;
    logic              reg_re_en;
    logic              ex_valid;
    logic [6:0]        ex_opcode;
    logic [D_SIZE-1:0] ex_op1;
    logic [D_SIZE-1:0] ex_op2;
    logic              stall_fetch;
    logic [CNT_W-1:0]  stall_count;

    modport slave (
        input  instr_valid_in, opcode_in, addr_op1_in, addr_op2_in, dest_in, reg_re_in,
        input  rf_data1, rf_data2, result_wb, df1, df2, freeze, clear,
        output addr_op1_rd2ex, addr_op2_rd2ex, dest_rd2ex, reg_re_en,
        output ex_valid, ex_opcode, ex_op1, ex_op2, stall_fetch, stall_count
    );

    modport master (
        output instr_valid_in, opcode_in, addr_op1_in, addr_op2_in, dest_in, reg_re_in,
        output rf_data1, rf_data2, result_wb, df1, df2, freeze, clear,
        input  addr_op1_rd2ex, addr_op2_rd2ex, dest_rd2ex, reg_re_en,
        input  ex_valid, ex_opcode, ex_op1, ex_op2, stall_fetch, stall_count
    );
endinterface

// File: rtl/rd2ex_operand_stage.sv
// READ->EXECUTE pipeline register with write-back forwarding, load-use stall and bubble insertion.
//   state | meaning
//   RUN   | rd2ex loads every cycle unless freeze; held instruction visible to EXECUTE
//   STALL | rd2ex held and patched from write-back; EXECUTE sees a bubble; FETCH held
module rd2ex_operand_stage #(
    parameter int D_SIZE       = 32,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic clk,
    input logic rst,
    rd2ex_operand_stage_if.slave bus
);
    localparam int CW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [2:0]        addr1_q, addr1_d;
    logic [2:0]        addr2_q, addr2_d;
    logic [2:0]        dest_q, dest_d;
    logic              reg_re_q, reg_re_d;
    logic [D_SIZE-1:0] op1_q, op1_d;
    logic [D_SIZE-1:0] op2_q, op2_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [D_SIZE-1:0] op1_fwd, op2_fwd;

    assign op1_fwd = bus.df1 ? bus.result_wb : op1_q;
    assign op2_fwd = bus.df2 ? bus.result_wb : op2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        opcode_d    = opcode_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        dest_d      = dest_q;
        reg_re_d    = reg_re_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (!bus.freeze) begin
                    valid_d  = bus.instr_valid_in;
                    opcode_d = bus.opcode_in;
                    addr1_d  = bus.addr_op1_in;
                    addr2_d  = bus.addr_op2_in;
                    dest_d   = bus.dest_in;
                    reg_re_d = bus.reg_re_in;
                    op1_d    = bus.rf_data1;
                    op2_d    = bus.rf_data2;
                end else begin
                    state_d = STALL;
                    cnt_d   = CW'(STALL_CYCLES - 1);
                    op1_d   = op1_fwd;
                    op2_d   = op2_fwd;
                end
            end
            STALL: begin
                // Patch the held operands so a write-back seen only during the stall survives.
                op1_d = op1_fwd;
                op2_d = op2_fwd;
                if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            opcode_q    <= '0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            dest_q      <= '0;
            reg_re_q    <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            opcode_q    <= opcode_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            dest_q      <= dest_d;
            reg_re_q    <= reg_re_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.addr_op1_rd2ex = addr1_q;
    assign bus.addr_op2_rd2ex = addr2_q;
    assign bus.dest_rd2ex     = dest_q;
    assign bus.reg_re_en      = reg_re_q;
    assign bus.ex_opcode      = opcode_q;
    assign bus.ex_op1         = op1_fwd;
    assign bus.ex_op2         = op2_fwd;
    assign bus.ex_valid       = valid_q & ~bus.clear & (state_q == RUN);
    // Gated by rst so FETCH is released in the very cycle reset is asserted.
    assign bus.stall_fetch    = rst & (((state_q == RUN) & bus.freeze) | (state_q == STALL));
    assign bus.stall_count    = stall_cnt_q;
endmodule

// File: tb/tb_rd2ex_operand_stage.sv
// Directed bench for rd2ex_operand_stage: EXECUTE issues are checked by a scoreboard monitor,
// stall/reset side effects by direct checks at the falling edge.
module tb_rd2ex_operand_stage;
    localparam int D  = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rd2ex_operand_stage_if #(.D_SIZE(D), .CNT_W(CW)) bus ();

    rd2ex_operand_stage #(.D_SIZE(D), .STALL_CYCLES(2), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [6:0]   opc;
        logic [D-1:0] op1;
        logic [D-1:0] op2;
        logic [2:0]   dest;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    task automatic expect_issue(input logic [6:0] opc, input logic [D-1:0] o1,
                                input logic [D-1:0] o2, input logic [2:0] dst);
        exp_t e;
        e.opc = opc; e.op1 = o1; e.op2 = o2; e.dest = dst;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] a1,
                         input logic [2:0] a2, input logic [2:0] dst,
                         input logic [D-1:0] d1, input logic [D-1:0] d2);
        bus.instr_valid_in = v;
        bus.opcode_in      = opc;
        bus.addr_op1_in    = a1;
        bus.addr_op2_in    = a2;
        bus.dest_in        = dst;
        bus.reg_re_in      = v;
        bus.rf_data1       = d1;
        bus.rf_data2       = d2;
    endtask

    // Monitor: every presented EXECUTE instruction must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.ex_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 64'(bus.ex_opcode), 64'h0);
                    check("unexpected_issue_valid", 64'(bus.ex_valid), 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_opcode", 64'(bus.ex_opcode), 64'(e.opc));
                    check("issue_op1",    64'(bus.ex_op1),    64'(e.op1));
                    check("issue_op2",    64'(bus.ex_op2),    64'(e.op2));
                    check("issue_dest",   64'(bus.dest_rd2ex), 64'(e.dest));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.df1 = 1'b0; bus.df2 = 1'b0; bus.clear = 1'b0; bus.result_wb = '0;
        // Reset with valid and freeze asserted: nothing may leak through.
        drive(1'b1, 7'h7F, 3'd1, 3'd1, 3'd1, 32'h99, 32'h98);
        bus.freeze = 1'b1;
        rst = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("rst_ex_valid",    64'(bus.ex_valid), 64'h0);
        check("rst_stall_fetch", 64'(bus.stall_fetch), 64'h0);
        check("rst_ex_op1",      64'(bus.ex_op1), 64'h0);
        check("rst_ex_op2",      64'(bus.ex_op2), 64'h0);
        check("rst_stall_count", 64'(bus.stall_count), 64'h0);
        @(posedge clk); #1;
        rst = 1'b1; bus.freeze = 1'b0;
        drive(1'b0, 7'h0, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0);
        tick();

        // Normal load, one-cycle latency.
        drive(1'b1, 7'h33, 3'd2, 3'd3, 3'd5, 32'h11, 32'h22);
        expect_issue(7'h33, 32'h11, 32'h22, 3'd5);
        tick();
        drive(1'b0, 7'h0, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("load_addr_op1", 64'(bus.addr_op1_rd2ex), 64'd2);
        check("load_addr_op2", 64'(bus.addr_op2_rd2ex), 64'd3);
        check("load_reg_re",   64'(bus.reg_re_en), 64'd1);
        tick();

        // Forward op1 only.
        drive(1'b1, 7'h44, 3'd2, 3'd3, 3'd6, 32'h11, 32'h22);
        expect_issue(7'h44, 32'hAB, 32'h22, 3'd6);
        tick();
        drive(1'b0, 7'h0, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0);
        check("pre_fwd_op1", 64'(bus.ex_op1), 64'h11);
        bus.df1 = 1'b1; bus.result_wb = 32'hAB;
        tick();
        bus.df1 = 1'b0;

        // Forward both operands.
        drive(1'b1, 7'h45, 3'd4, 3'd4, 3'd7, 32'h1234, 32'h5678);
        expect_issue(7'h45, 32'h77, 32'h77, 3'd7);
        tick();
        drive(1'b0, 7'h0, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0);
        bus.df1 = 1'b1; bus.df2 = 1'b1; bus.result_wb = 32'h77;
        tick();
        bus.df1 = 1'b0; bus.df2 = 1'b0;

        // Freeze+clear pulse, STALL_CYCLES=2, op1 patched in stall cycle 1.
        drive(1'b1, 7'h12, 3'd1, 3'd7, 3'd4, 32'h101, 32'h202);
        expect_issue(7'h12, 32'h55, 32'h202, 3'd4);
        tick();
        bus.freeze = 1'b1; bus.clear = 1'b1;
        drive(1'b1, 7'h66, 3'd6, 3'd6, 3'd6, 32'hDEAD, 32'hBEEF);
        @(negedge clk);
        check("frz_stall_fetch_c0", 64'(bus.stall_fetch), 64'h1);
        check("frz_ex_valid_c0",    64'(bus.ex_valid), 64'h0);
        tick();
        bus.freeze = 1'b0; bus.clear = 1'b0;
        bus.df1 = 1'b1; bus.result_wb = 32'h55;
        drive(1'b1, 7'h67, 3'd5, 3'd5, 3'd5, 32'hCAFE, 32'hF00D);
        @(negedge clk);
        check("frz_stall_fetch_c1", 64'(bus.stall_fetch), 64'h1);
        check("frz_ex_valid_c1",    64'(bus.ex_valid), 64'h0);
        check("frz_held_addr_op1",  64'(bus.addr_op1_rd2ex), 64'd1);
        tick();
        bus.df1 = 1'b0; bus.result_wb = 32'h0;
        bus.freeze = 1'b1;
        @(negedge clk);
        check("frz_stall_fetch_c2", 64'(bus.stall_fetch), 64'h1);
        check("frz_ex_valid_c2",    64'(bus.ex_valid), 64'h0);
        check("frz_stall_count_c2", 64'(bus.stall_count), 64'd1);
        tick();
        bus.freeze = 1'b0;
        drive(1'b0, 7'h0, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("reissue_stall_fetch", 64'(bus.stall_fetch), 64'h0);
        check("reissue_stall_count", 64'(bus.stall_count), 64'd2);
        tick();

        // Reset in the middle of a stall drops the held instruction.
        drive(1'b1, 7'h21, 3'd3, 3'd3, 3'd3, 32'h333, 32'h444);
        tick();
        bus.freeze = 1'b1; bus.clear = 1'b1;
        drive(1'b0, 7'h0, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0);
        tick();
        bus.freeze = 1'b0; bus.clear = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_stall_fetch", 64'(bus.stall_fetch), 64'h0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ex_valid",    64'(bus.ex_valid), 64'h0);
        check("post_rst_stall_fetch", 64'(bus.stall_fetch), 64'h0);
        check("post_rst_stall_count", 64'(bus.stall_count), 64'd0);
        check("post_rst_ex_op1",      64'(bus.ex_op1), 64'h0);
        @(posedge clk); #1;

        // Normal loading resumes.
        drive(1'b1, 7'h5A, 3'd6, 3'd2, 3'd1, 32'hA5A5, 32'h5A5A);
        expect_issue(7'h5A, 32'hA5A5, 32'h5A5A, 3'd1);
        tick();
        drive(1'b0, 7'h0, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0);
        tick(); tick();
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
